// File: rtl/vram_port_arbiter.sv
// -----------------------------------------------------------------------------
// vram_port_arbiter
//
// Shares a single video-memory port between the CPU (load/store) and the VGA
// scan-out fetch engine. One access is granted per clock. VGA normally wins,
// but after MAX_VGA_STREAK consecutive VGA grants while the CPU is waiting, the
// CPU is guaranteed the next slot (unless VGA is flagged urgent). Memory
// commands are registered. Read data is steered back to whichever requester
// issued the read, using a tag pipeline matched to the memory read latency.
//
// Ports
//   CLOCK_50            system clock, rising edge
//   resetn              asynchronous active-low reset
//   vga_req/vga_urgent  VGA fetch request / line buffer near underrun
//   vga_addr            VGA read word address
//   vga_gnt             VGA request accepted this cycle (combinational)
//   vga_rvalid/rdata    VGA read return (rdata is 0 while rvalid is 0)
//   cpu_req/we          CPU access request, 1 = write
//   cpu_addr/wdata      CPU word address / write data
//   cpu_gnt             CPU request accepted this cycle (combinational)
//   cpu_rvalid/rdata    CPU read return (rdata is 0 while rvalid is 0)
//   mem_addr/wdata      registered memory address / write data
//   mem_wren/rden       registered write / read enables
//   mem_q               memory read data, valid RD_LAT cycles after mem_rden
// -----------------------------------------------------------------------------
module vram_port_arbiter #(
  parameter int ADDR_W         = 15,
  parameter int DATA_W         = 32,
  parameter int RD_LAT         = 2,
  parameter int MAX_VGA_STREAK = 4
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              vga_req,
  input  logic              vga_urgent,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [0:0] {
    PRI_VGA = 1'b0,
    PRI_CPU = 1'b1
  } pri_state_t;

  // Owner encoding carried through the tag pipeline.
  localparam logic OWN_VGA = 1'b0;
  localparam logic OWN_CPU = 1'b1;

  localparam logic [3:0] STREAK_MAX  = 4'(MAX_VGA_STREAK);
  localparam logic [3:0] STREAK_LAST = 4'(MAX_VGA_STREAK - 1);

  pri_state_t          state_r;
  logic [3:0]          streak_cnt_r;

  logic                vga_gnt_s;
  logic                cpu_gnt_s;
  logic                rd_xfer_s;
  logic                rd_owner_s;

  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic                mem_wren_r;
  logic                mem_rden_r;

  // Tag pipeline: stage 0 is loaded at the same edge as the memory command,
  // so stage RD_LAT-1 is valid in the cycle just before mem_q holds the data.
  logic [RD_LAT-1:0]   tag_valid_r;
  logic [RD_LAT-1:0]   tag_owner_r;

  logic                vga_rvalid_r;
  logic                cpu_rvalid_r;

  // Grant selection: depends only on request inputs and registered state.
  always_comb begin
    vga_gnt_s = 1'b0;
    cpu_gnt_s = 1'b0;
    case (state_r)
      PRI_VGA: begin
        if (vga_req) begin
          vga_gnt_s = 1'b1;
        end else if (cpu_req) begin
          cpu_gnt_s = 1'b1;
        end else begin
          vga_gnt_s = 1'b0;
          cpu_gnt_s = 1'b0;
        end
      end
      PRI_CPU: begin
        // Urgent VGA overrides fairness; an idle CPU never blocks VGA.
        if (vga_req && vga_urgent) begin
          vga_gnt_s = 1'b1;
        end else if (cpu_req) begin
          cpu_gnt_s = 1'b1;
        end else if (vga_req) begin
          vga_gnt_s = 1'b1;
        end else begin
          vga_gnt_s = 1'b0;
          cpu_gnt_s = 1'b0;
        end
      end
      default: begin
        vga_gnt_s = 1'b0;
        cpu_gnt_s = 1'b0;
      end
    endcase
  end

  // Classify the current transfer for the tag pipeline.
  always_comb begin
    rd_xfer_s  = 1'b0;
    rd_owner_s = OWN_VGA;
    if (vga_gnt_s) begin
      rd_xfer_s  = 1'b1;
      rd_owner_s = OWN_VGA;
    end else if (cpu_gnt_s) begin
      rd_xfer_s  = ~cpu_we;
      rd_owner_s = OWN_CPU;
    end else begin
      rd_xfer_s  = 1'b0;
      rd_owner_s = OWN_VGA;
    end
  end

  // Fairness FSM and VGA streak counter.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_r      <= PRI_VGA;
      streak_cnt_r <= 4'd0;
    end else begin
      case (state_r)
        PRI_VGA: begin
          if (vga_gnt_s && cpu_req && (streak_cnt_r == STREAK_LAST)) begin
            state_r <= PRI_CPU;
          end else begin
            state_r <= PRI_VGA;
          end
        end
        PRI_CPU: begin
          if (cpu_gnt_s || !cpu_req) begin
            state_r <= PRI_VGA;
          end else begin
            state_r <= PRI_CPU;
          end
        end
        default: begin
          state_r <= PRI_VGA;
        end
      endcase

      // The streak only measures how long a waiting CPU has been passed over.
      if (!cpu_req || cpu_gnt_s) begin
        streak_cnt_r <= 4'd0;
      end else if (vga_gnt_s && (streak_cnt_r != STREAK_MAX)) begin
        streak_cnt_r <= streak_cnt_r + 4'd1;
      end else begin
        streak_cnt_r <= streak_cnt_r;
      end
    end
  end

  // Registered memory command; address and write data hold when idle.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_wren_r  <= 1'b0;
      mem_rden_r  <= 1'b0;
    end else if (vga_gnt_s) begin
      mem_addr_r  <= vga_addr;
      mem_wren_r  <= 1'b0;
      mem_rden_r  <= 1'b1;
    end else if (cpu_gnt_s) begin
      mem_addr_r  <= cpu_addr;
      mem_wdata_r <= cpu_wdata;
      mem_wren_r  <= cpu_we;
      mem_rden_r  <= ~cpu_we;
    end else begin
      mem_wren_r  <= 1'b0;
      mem_rden_r  <= 1'b0;
    end
  end

  // Tag pipeline shift plus registered per-owner read-valid outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      tag_valid_r  <= '0;
      tag_owner_r  <= '0;
      vga_rvalid_r <= 1'b0;
      cpu_rvalid_r <= 1'b0;
    end else begin
      tag_valid_r[0] <= rd_xfer_s;
      tag_owner_r[0] <= rd_owner_s;
      for (int k = 1; k < RD_LAT; k++) begin
        tag_valid_r[k] <= tag_valid_r[k-1];
        tag_owner_r[k] <= tag_owner_r[k-1];
      end
      vga_rvalid_r <= tag_valid_r[RD_LAT-1] & (tag_owner_r[RD_LAT-1] == OWN_VGA);
      cpu_rvalid_r <= tag_valid_r[RD_LAT-1] & (tag_owner_r[RD_LAT-1] == OWN_CPU);
    end
  end

  assign vga_gnt    = vga_gnt_s;
  assign cpu_gnt    = cpu_gnt_s;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_wren   = mem_wren_r;
  assign mem_rden   = mem_rden_r;
  assign vga_rvalid = vga_rvalid_r;
  assign cpu_rvalid = cpu_rvalid_r;

  // mem_q arrives in the same cycle as rvalid, so read data is gated rather
  // than registered; it reads 0 whenever the owner's rvalid is low.
  assign vga_rdata  = vga_rvalid_r ? mem_q : '0;
  assign cpu_rdata  = cpu_rvalid_r ? mem_q : '0;

endmodule

// File: tb/tb_vram_port_arbiter.sv
module tb_vram_port_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int NV = 24;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          vga_req = 1'b0;
  logic          vga_urgent = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic          vga_gnt;
  logic          vga_rvalid;
  logic [DW-1:0] vga_rdata;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wren;
  logic          mem_rden;
  logic [DW-1:0] mem_q = '0;

  int checks = 0;
  int failures = 0;

  vram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .MAX_VGA_STREAK(4)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn),
    .vga_req(vga_req), .vga_urgent(vga_urgent), .vga_addr(vga_addr),
    .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rden(mem_rden), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Memory contents: unwritten words hold an address-derived pattern.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return 32'hA5A5_0000 ^ {17'd0, a};
  endfunction

  // Two-cycle read latency model: address sampled at the end of the command
  // cycle, data registered once more.
  logic [DW-1:0] wr_mem [int];
  logic [DW-1:0] rd1 = '0;
  always @(posedge clk) begin
    if (mem_wren) wr_mem[int'(mem_addr)] = mem_wdata;
    rd1   <= wr_mem.exists(int'(mem_addr)) ? wr_mem[int'(mem_addr)] : pat(mem_addr);
    mem_q <= rd1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic v;
    logic u;
    logic c;
    logic ev;
    logic ec;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(input logic v, input logic u, input logic c,
                              input logic ev, input logic ec);
    vec_t r;
    r.v = v; r.u = u; r.c = c; r.ev = ev; r.ec = ec;
    return r;
  endfunction

  initial begin
    // Grant sequence from reset (state PRI_VGA, streak 0), one row per cycle.
    tbl[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // idle
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); // VGA alone
    tbl[2]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); // CPU alone
    tbl[3]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0); // V streak 1
    tbl[4]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0); // V 2
    tbl[5]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0); // V 3
    tbl[6]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0); // V 4 -> PRI_CPU
    tbl[7]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1); // C -> PRI_VGA
    tbl[8]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[9]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[10] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[11] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0); // -> PRI_CPU
    tbl[12] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0); // urgent overrides, stays PRI_CPU
    tbl[13] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[14] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1); // urgent w/o vga_req: CPU wins
    tbl[15] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0); // back in PRI_VGA, V 1
    tbl[16] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[17] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[18] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0); // -> PRI_CPU
    tbl[19] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); // cpu idle: V, -> PRI_VGA
    tbl[20] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0); // PRI_VGA again, streak 1
    tbl[21] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0); // streak 2
    tbl[22] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); // cpu drops: streak clears
    tbl[23] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0); // streak restarts at 1, still V

    // Reset state.
    #12;
    chk("rst mem_addr", 32'(mem_addr), 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst mem_wren", 32'(mem_wren), 32'h0);
    chk("rst mem_rden", 32'(mem_rden), 32'h0);
    chk("rst vga_rvalid", 32'(vga_rvalid), 32'h0);
    chk("rst cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    chk("rst vga_rdata", vga_rdata, 32'h0);
    chk("rst cpu_rdata", cpu_rdata, 32'h0);
    chk("rst gnts", {30'd0, vga_gnt, cpu_gnt}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    next_cycle();

    // Table-driven grant/fairness sequence.
    vga_addr = 15'h0200;
    cpu_addr = 15'h0100;
    cpu_we   = 1'b0;
    for (int i = 0; i < NV; i++) begin
      vga_req    = tbl[i].v;
      vga_urgent = tbl[i].u;
      cpu_req    = tbl[i].c;
      @(negedge clk);
      chk($sformatf("tbl%0d vga_gnt", i), 32'(vga_gnt), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d cpu_gnt", i), 32'(cpu_gnt), 32'(tbl[i].ec));
      next_cycle();
    end
    vga_req = 1'b0; vga_urgent = 1'b0; cpu_req = 1'b0;
    repeat (5) next_cycle();

    // Single CPU read of 0x0123.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0123;
    @(negedge clk);
    chk("A c0 cpu_gnt", 32'(cpu_gnt), 32'h1);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("A c1 mem_addr", 32'(mem_addr), 32'h0123);
    chk("A c1 mem_rden", 32'(mem_rden), 32'h1);
    chk("A c1 mem_wren", 32'(mem_wren), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("A c2 cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    chk("A c2 mem_rden", 32'(mem_rden), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("A c3 cpu_rvalid", 32'(cpu_rvalid), 32'h1);
    chk("A c3 cpu_rdata", cpu_rdata, pat(15'h0123));
    chk("A c3 vga_rvalid", 32'(vga_rvalid), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("A c4 cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    chk("A c4 cpu_rdata", cpu_rdata, 32'h0);
    next_cycle();

    // CPU write to the top address.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h7FFF; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("B c0 cpu_gnt", 32'(cpu_gnt), 32'h1);
    next_cycle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = 32'h0;
    @(negedge clk);
    chk("B c1 mem_wren", 32'(mem_wren), 32'h1);
    chk("B c1 mem_rden", 32'(mem_rden), 32'h0);
    chk("B c1 mem_addr", 32'(mem_addr), 32'h7FFF);
    chk("B c1 mem_wdata", mem_wdata, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    chk("B c2 mem_wren", 32'(mem_wren), 32'h0);
    chk("B c2 mem_addr hold", 32'(mem_addr), 32'h7FFF);
    chk("B c2 mem_wdata hold", mem_wdata, 32'hDEADBEEF);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("B no cpu_rvalid %0d", k), 32'(cpu_rvalid), 32'h0);
      next_cycle();
      @(negedge clk);
    end
    next_cycle();

    // Interleaved reads V(0x10), C(0x20), V(0x11).
    vga_req = 1'b1; vga_addr = 15'h0010;
    @(negedge clk);
    chk("C c0 vga_gnt", 32'(vga_gnt), 32'h1);
    next_cycle();
    vga_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0020;
    @(negedge clk);
    chk("C c1 cpu_gnt", 32'(cpu_gnt), 32'h1);
    next_cycle();
    cpu_req = 1'b0; vga_req = 1'b1; vga_addr = 15'h0011;
    @(negedge clk);
    chk("C c2 vga_gnt", 32'(vga_gnt), 32'h1);
    next_cycle();
    vga_req = 1'b0;
    @(negedge clk);
    chk("C c3 rvalids", {30'd0, vga_rvalid, cpu_rvalid}, 32'h2);
    chk("C c3 vga_rdata", vga_rdata, pat(15'h0010));
    next_cycle();
    @(negedge clk);
    chk("C c4 rvalids", {30'd0, vga_rvalid, cpu_rvalid}, 32'h1);
    chk("C c4 cpu_rdata", cpu_rdata, pat(15'h0020));
    next_cycle();
    @(negedge clk);
    chk("C c5 rvalids", {30'd0, vga_rvalid, cpu_rvalid}, 32'h2);
    chk("C c5 vga_rdata", vga_rdata, pat(15'h0011));
    next_cycle();
    @(negedge clk);
    chk("C c6 rvalids", {30'd0, vga_rvalid, cpu_rvalid}, 32'h0);
    next_cycle();

    // Reset pulse with two reads in flight.
    vga_req = 1'b1; vga_addr = 15'h0030;
    @(negedge clk);
    chk("D c0 vga_gnt", 32'(vga_gnt), 32'h1);
    next_cycle();
    vga_req = 1'b0; cpu_req = 1'b1; cpu_addr = 15'h0031;
    @(negedge clk);
    chk("D c1 cpu_gnt", 32'(cpu_gnt), 32'h1);
    next_cycle();
    cpu_req = 1'b0;
    resetn = 1'b0;
    #1;
    chk("D rst mem_rden", 32'(mem_rden), 32'h0);
    chk("D rst mem_addr", 32'(mem_addr), 32'h0);
    chk("D rst mem_wdata", mem_wdata, 32'h0);
    chk("D rst rvalids", {30'd0, vga_rvalid, cpu_rvalid}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("D no rvalid %0d", k), {30'd0, vga_rvalid, cpu_rvalid}, 32'h0);
    end
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 15'h0040;
    @(negedge clk);
    chk("D post cpu_gnt", 32'(cpu_gnt), 32'h1);
    next_cycle();
    cpu_req = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("D post cpu_rvalid", 32'(cpu_rvalid), 32'h1);
    chk("D post cpu_rdata", cpu_rdata, pat(15'h0040));
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares one 32-bit video-memory port between the pipelined CPU (load/store) and the VGA scan-out fetch engine.
- Grants one access per clock. VGA has priority, but a bounded-starvation rule guarantees the CPU one slot after at most MAX_VGA_STREAK consecutive VGA grants.
- Memory commands are registered. Read data is steered back to the requester that issued the read, via a latency-matched tag pipeline.
- Sits between mips_pipeline, vga_adapter and the altsyncram port, in the CLOCK_50 domain.

Parameters:
- ADDR_W, 15, word address width of the memory port.
- DATA_W, 32, data width.
- RD_LAT, 2, memory read latency in cycles from command cycle to valid mem_q (1..4).
- MAX_VGA_STREAK, 4, maximum consecutive VGA grants while cpu_req is pending (1..15).

Ports:
- CLOCK_50 input 1 system clock; all logic on rising edge.
- resetn input 1 asynchronous, active-low reset.
- vga_req input 1 VGA fetch request.
- vga_urgent input 1 VGA line buffer near underrun; overrides fairness.
- vga_addr input ADDR_W VGA read word address.
- vga_gnt output 1 VGA request accepted this cycle (combinational).
- vga_rvalid output 1 vga_rdata valid.
- vga_rdata output DATA_W VGA read data.
- cpu_req input 1 CPU access request.
- cpu_we input 1 1 = write, 0 = read.
- cpu_addr input ADDR_W CPU word address.
- cpu_wdata input DATA_W CPU write data.
- cpu_gnt output 1 CPU request accepted this cycle (combinational).
- cpu_rvalid output 1 cpu_rdata valid.
- cpu_rdata output DATA_W CPU read data.
- mem_addr output ADDR_W registered memory address.
- mem_wdata output DATA_W registered write data.
- mem_wren output 1 registered write enable.
- mem_rden output 1 registered read enable.
- mem_q input DATA_W memory read data.

Behaviour:
- Reset: asynchronous on resetn = 0. Clears mem_addr, mem_wdata, mem_wren, mem_rden, vga_rvalid, cpu_rvalid, the tag pipeline and streak_cnt. State returns to PRI_VGA. vga_rdata and cpu_rdata read 0 while rvalid = 0.
- Handshake:
  - A transfer occurs in any cycle where req & gnt.
  - The requester holds req, addr, we and wdata stable until the transfer. It may present the next request in the following cycle.
  - gnt is a function of the current req inputs and registered state only. It never depends on mem_q.
  - At most one of vga_gnt and cpu_gnt is high per cycle.
- FSM state PRI_VGA:
  - vga_req wins if present.
  - cpu_req wins when vga_req = 0.
  - Move to PRI_CPU when a VGA transfer occurs with cpu_req = 1 and streak_cnt = MAX_VGA_STREAK - 1.
- FSM state PRI_CPU:
  - cpu_req wins unless vga_urgent = 1, in which case VGA wins and the state stays PRI_CPU.
  - Return to PRI_VGA after a CPU transfer, or when cpu_req = 0.
- streak_cnt:
  - Increments on each VGA transfer made while cpu_req = 1, saturating at MAX_VGA_STREAK.
  - Clears on any CPU transfer, and in any cycle where cpu_req = 0.
- Command timing:
  - A transfer in cycle t drives mem_addr, mem_wdata, mem_wren and mem_rden in cycle t+1.
  - With no transfer, mem_wren = mem_rden = 0 in t+1 and mem_addr/mem_wdata hold their previous values.
  - A CPU write sets mem_wren = 1, mem_rden = 0. Any read sets mem_rden = 1.
- Read return:
  - The tag pipeline is RD_LAT deep and carries {valid, owner}, shifted every cycle.
  - For a read transfer in cycle t, the owner's rvalid = 1 in cycle t+1+RD_LAT exactly, for one cycle, with rdata = mem_q.
  - Returns are in issue order. Back-to-back reads from either requester, one per cycle, are supported at full rate with no bubbles.
- CPU writes produce no rvalid.
- There is no read/write hazard logic; the single port serializes accesses in grant order.
- Reset mid-operation discards in-flight reads: no rvalid is asserted after resetn deasserts for reads issued before reset.
- Simultaneous vga_urgent and PRI_CPU: VGA wins; the CPU is served on the next cycle with vga_urgent = 0.
- Unknown/idle: the requester side sees gnt = 0 when its req = 0.

Test Plan:
- Reset, then a single CPU read to address 0x0123 with vga_req = 0 -> cpu_gnt = 1 in cycle 0; mem_addr = 0x0123, mem_rden = 1 in cycle 1; cpu_rvalid = 1 in cycle 3 with cpu_rdata = mem_q (RD_LAT = 2).
- CPU write addr 0x7FFF, data 0xDEADBEEF -> mem_wren = 1, mem_addr = 0x7FFF, mem_wdata = 0xDEADBEEF one cycle after grant; no cpu_rvalid.
- vga_req and cpu_req both held high continuously (MAX_VGA_STREAK = 4) -> grant sequence V,V,V,V,C repeating; cpu_gnt never delayed more than 4 cycles.
- Fairness state PRI_CPU with vga_urgent = 1 -> vga_gnt = 1; cpu_gnt follows on the first cycle vga_urgent = 0.
- Interleaved reads V(0x10), C(0x20), V(0x11) in consecutive cycles -> vga_rvalid, cpu_rvalid, vga_rvalid in cycles 3, 4, 5, each with data matching the model RAM at its address.
- resetn pulsed low one cycle after two reads issued -> all outputs 0 immediately; no rvalid ever asserted for those reads; the next request is granted normally.
